// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode-settle, then execute,
// iterative multiply, write-back or halt. Strobes are decoded from state
// (mul_start is registered), so no output depends combinationally on inputs.
module instr_seq_ctrl #(
  parameter int PC_W       = 8,
  parameter int MUL_CYCLES = 16,
  parameter int RESET_PC   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            stop,
  input  logic            mem_ack,
  input  logic [15:0]     instr,
  input  logic [7:0]      cmd,
  output logic            fetch_req,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir,
  output logic            exec_en,
  output logic            mul_start,
  output logic            mul_busy,
  output logic            wb_en,
  output logic            halted,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MUL    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            mul_start_q, mul_start_d;
  logic            run_q, run_d;
  logic            run_rise;

  assign run_rise = run & ~run_q;

  // State register and datapath flops; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= PC_W'(RESET_PC);
      ir_q        <= '0;
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      mul_start_q <= mul_start_d;
      run_q       <= run_d;
    end
  end

  // Next-state, pc/ir update and multiply cycle counting
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    mul_start_d = 1'b0;
    run_d       = run;
    unique case (state_q)
      IDLE: begin
        if (run_rise) state_d = FETCH;
      end
      FETCH: begin
        if (mem_ack) begin
          ir_d    = instr;
          pc_d    = pc_q + PC_W'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        // halt outranks multiply; anything else is a single-cycle op
        if (cmd[6]) begin
          state_d = HALT;
        end else if (cmd[0]) begin
          state_d     = MUL;
          cnt_d       = 8'(MUL_CYCLES - 1);
          mul_start_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = WB;
      end
      MUL: begin
        if (cnt_q == 8'd0) state_d = WB;
        else               cnt_d   = cnt_q - 8'd1;
      end
      WB: begin
        state_d = stop ? IDLE : FETCH;
      end
      HALT: begin
        if (run_rise) state_d = FETCH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state     = state_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign fetch_req = (state_q == FETCH);
  assign exec_en   = (state_q == EXEC);
  assign mul_start = mul_start_q;
  assign mul_busy  = (state_q == MUL);
  assign wb_en     = (state_q == WB);
  assign halted    = (state_q == IDLE) || (state_q == HALT);

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scenario bench for instr_seq_ctrl: each row pairs the inputs for one clock
// with the expected outputs just after that clock.
module tb_instr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, stop, mem_ack;
  logic [15:0] instr;
  logic [7:0]  cmd;
  logic        fetch_req, exec_en, mul_start, mul_busy, wb_en, halted;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [2:0]  state;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        rst, run, stop, ack;
    logic [15:0] instr;
    logic [7:0]  cmd;
    logic [32:0] exp;   // {state, fetch_req, exec_en, mul_start, mul_busy, wb_en, halted, pc, ir}
  } row_t;

  row_t        sb_q[$];
  row_t        r;
  logic [32:0] obs;

  instr_seq_ctrl #(.PC_W(8), .MUL_CYCLES(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .run(run), .stop(stop), .mem_ack(mem_ack),
    .instr(instr), .cmd(cmd), .fetch_req(fetch_req), .pc(pc), .ir(ir),
    .exec_en(exec_en), .mul_start(mul_start), .mul_busy(mul_busy),
    .wb_en(wb_en), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, fetch_req, exec_en, mul_start, mul_busy, wb_en, halted, pc, ir};

  // Queue one clock of stimulus with its expected outcome; strobes follow from the expected state
  task automatic push(input logic rs, input logic rn, input logic sp, input logic ak,
                      input logic [15:0] in, input logic [7:0] cm,
                      input logic [2:0] st, input logic [7:0] p, input logic [15:0] i,
                      input logic ms);
    row_t n;
    n.rst = rs; n.run = rn; n.stop = sp; n.ack = ak; n.instr = in; n.cmd = cm;
    n.exp = {st, st == 3'd1, st == 3'd3, ms, st == 3'd4, st == 3'd5,
             (st == 3'd0) || (st == 3'd6), p, i};
    sb_q.push_back(n);
  endtask

  task automatic apply(input row_t x);
    rst = x.rst; run = x.run; stop = x.stop; mem_ack = x.ack; instr = x.instr; cmd = x.cmd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    push(1, 0, 0, 0, 16'h0000, 8'h00, 3'd0, 8'h00, 16'h0000, 0);
    for (int k = 0; sb_q.size() != 0; k++) begin
      r = sb_q.pop_front(); apply(r); checks++;
      if (obs !== r.exp)
        $display("FAIL reset row%0d: got st=%0d str=%b pc=%h ir=%h, want st=%0d str=%b pc=%h ir=%h",
                 k, obs[32:30], obs[29:24], obs[23:16], obs[15:0], r.exp[32:30], r.exp[29:24], r.exp[23:16], r.exp[15:0]);
      else passed++;
    end
  endtask

  task automatic test_single_op();
    push(0, 1, 0, 1, 16'h1234, 8'h00, 3'd1, 8'h00, 16'h0000, 0);
    push(0, 0, 0, 1, 16'h1234, 8'h00, 3'd2, 8'h01, 16'h1234, 0);
    push(0, 0, 0, 1, 16'h1234, 8'h00, 3'd3, 8'h01, 16'h1234, 0);
    push(0, 0, 0, 1, 16'h1234, 8'h00, 3'd5, 8'h01, 16'h1234, 0);
    push(0, 0, 0, 1, 16'h1234, 8'h00, 3'd1, 8'h01, 16'h1234, 0);
    for (int k = 0; sb_q.size() != 0; k++) begin
      r = sb_q.pop_front(); apply(r); checks++;
      if (obs !== r.exp)
        $display("FAIL single_op row%0d: got st=%0d str=%b pc=%h ir=%h, want st=%0d str=%b pc=%h ir=%h",
                 k, obs[32:30], obs[29:24], obs[23:16], obs[15:0], r.exp[32:30], r.exp[29:24], r.exp[23:16], r.exp[15:0]);
      else passed++;
    end
  endtask

  task automatic test_multiply();
    push(0, 0, 0, 1, 16'h8000, 8'h01, 3'd2, 8'h02, 16'h8000, 0);
    push(0, 0, 0, 1, 16'h8000, 8'h01, 3'd4, 8'h02, 16'h8000, 1);
    for (int c = 1; c < 16; c++)
      push(0, 0, 0, 1, 16'h8000, 8'h01, 3'd4, 8'h02, 16'h8000, 0);
    push(0, 0, 0, 1, 16'h8000, 8'h01, 3'd5, 8'h02, 16'h8000, 0);
    push(0, 0, 0, 1, 16'h8000, 8'h01, 3'd1, 8'h02, 16'h8000, 0);
    for (int k = 0; sb_q.size() != 0; k++) begin
      r = sb_q.pop_front(); apply(r); checks++;
      if (obs !== r.exp)
        $display("FAIL multiply row%0d: got st=%0d str=%b pc=%h ir=%h, want st=%0d str=%b pc=%h ir=%h",
                 k, obs[32:30], obs[29:24], obs[23:16], obs[15:0], r.exp[32:30], r.exp[29:24], r.exp[23:16], r.exp[15:0]);
      else passed++;
    end
  endtask

  task automatic test_halt_resume();
    push(0, 1, 0, 1, 16'hF000, 8'h40, 3'd2, 8'h03, 16'hF000, 0);
    for (int c = 0; c < 4; c++)
      push(0, 1, 0, 1, 16'hF000, 8'h40, 3'd6, 8'h03, 16'hF000, 0);
    push(0, 0, 0, 1, 16'hF000, 8'h40, 3'd6, 8'h03, 16'hF000, 0);
    push(0, 1, 0, 1, 16'hF000, 8'h40, 3'd1, 8'h03, 16'hF000, 0);
    for (int k = 0; sb_q.size() != 0; k++) begin
      r = sb_q.pop_front(); apply(r); checks++;
      if (obs !== r.exp)
        $display("FAIL halt_resume row%0d: got st=%0d str=%b pc=%h ir=%h, want st=%0d str=%b pc=%h ir=%h",
                 k, obs[32:30], obs[29:24], obs[23:16], obs[15:0], r.exp[32:30], r.exp[29:24], r.exp[23:16], r.exp[15:0]);
      else passed++;
    end
  endtask

  task automatic test_pc_wrap_wait();
    for (int op = 3; op < 255; op++) begin
      push(0, 0, 0, 1, 16'h1000, 8'h00, 3'd2, 8'(op + 1), 16'h1000, 0);
      push(0, 0, 0, 1, 16'h1000, 8'h00, 3'd3, 8'(op + 1), 16'h1000, 0);
      push(0, 0, 0, 1, 16'h1000, 8'h00, 3'd5, 8'(op + 1), 16'h1000, 0);
      push(0, 0, 0, 1, 16'h1000, 8'h00, 3'd1, 8'(op + 1), 16'h1000, 0);
    end
    for (int c = 0; c < 5; c++)
      push(0, 0, 0, 0, 16'hABCD, 8'h00, 3'd1, 8'hFF, 16'h1000, 0);
    push(0, 0, 0, 1, 16'h2345, 8'h00, 3'd2, 8'h00, 16'h2345, 0);
    push(0, 0, 0, 1, 16'h2345, 8'h00, 3'd3, 8'h00, 16'h2345, 0);
    push(0, 0, 0, 1, 16'h2345, 8'h00, 3'd5, 8'h00, 16'h2345, 0);
    push(0, 0, 0, 1, 16'h2345, 8'h00, 3'd1, 8'h00, 16'h2345, 0);
    for (int k = 0; sb_q.size() != 0; k++) begin
      r = sb_q.pop_front(); apply(r); checks++;
      if (obs !== r.exp)
        $display("FAIL pc_wrap_wait row%0d: got st=%0d str=%b pc=%h ir=%h, want st=%0d str=%b pc=%h ir=%h",
                 k, obs[32:30], obs[29:24], obs[23:16], obs[15:0], r.exp[32:30], r.exp[29:24], r.exp[23:16], r.exp[15:0]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_mul();
    push(0, 0, 0, 1, 16'h8000, 8'h01, 3'd2, 8'h01, 16'h8000, 0);
    push(0, 0, 0, 1, 16'h8000, 8'h01, 3'd4, 8'h01, 16'h8000, 1);
    for (int c = 0; c < 8; c++)
      push(0, 0, 0, 1, 16'h8000, 8'h01, 3'd4, 8'h01, 16'h8000, 0);
    push(1, 0, 0, 1, 16'h8000, 8'h01, 3'd0, 8'h00, 16'h0000, 0);
    push(0, 0, 0, 1, 16'h8000, 8'h01, 3'd0, 8'h00, 16'h0000, 0);
    for (int k = 0; sb_q.size() != 0; k++) begin
      r = sb_q.pop_front(); apply(r); checks++;
      if (obs !== r.exp)
        $display("FAIL reset_mid_mul row%0d: got st=%0d str=%b pc=%h ir=%h, want st=%0d str=%b pc=%h ir=%h",
                 k, obs[32:30], obs[29:24], obs[23:16], obs[15:0], r.exp[32:30], r.exp[29:24], r.exp[23:16], r.exp[15:0]);
      else passed++;
    end
  endtask

  task automatic test_priority_stop();
    push(0, 1, 0, 1, 16'hF000, 8'h41, 3'd1, 8'h00, 16'h0000, 0);
    push(0, 1, 0, 1, 16'hF000, 8'h41, 3'd2, 8'h01, 16'hF000, 0);
    push(0, 1, 0, 1, 16'hF000, 8'h41, 3'd6, 8'h01, 16'hF000, 0);
    push(0, 0, 0, 1, 16'hF000, 8'h41, 3'd6, 8'h01, 16'hF000, 0);
    push(0, 1, 0, 1, 16'h7000, 8'h80, 3'd1, 8'h01, 16'hF000, 0);
    push(0, 0, 1, 1, 16'h7000, 8'h80, 3'd2, 8'h02, 16'h7000, 0);
    push(0, 0, 1, 1, 16'h7000, 8'h80, 3'd3, 8'h02, 16'h7000, 0);
    push(0, 0, 1, 1, 16'h7000, 8'h80, 3'd5, 8'h02, 16'h7000, 0);
    push(0, 0, 1, 1, 16'h7000, 8'h80, 3'd0, 8'h02, 16'h7000, 0);
    push(0, 0, 1, 1, 16'h7000, 8'h80, 3'd0, 8'h02, 16'h7000, 0);
    for (int k = 0; sb_q.size() != 0; k++) begin
      r = sb_q.pop_front(); apply(r); checks++;
      if (obs !== r.exp)
        $display("FAIL priority_stop row%0d: got st=%0d str=%b pc=%h ir=%h, want st=%0d str=%b pc=%h ir=%h",
                 k, obs[32:30], obs[29:24], obs[23:16], obs[15:0], r.exp[32:30], r.exp[29:24], r.exp[23:16], r.exp[15:0]);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; stop = 1'b0; mem_ack = 1'b0; instr = '0; cmd = '0;
    test_reset();
    test_single_op();
    test_multiply();
    test_halt_resume();
    test_pc_wrap_wait();
    test_reset_mid_mul();
    test_priority_stop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
